axi_rd_arbiter: RTL
===================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter ID_INST, default 4'd0, AXI ARID driven for instruction-fetch grants.
REQ-002 Parameter ID_DATA, default 4'd1, AXI ARID driven for data-read grants.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 io_inst_req_valid / io_data_req_valid  input  1  read request pending.
REQ-006 io_inst_req_ready / io_data_req_ready  output  1  request accepted this cycle.
REQ-007 io_inst_req_addr / io_data_req_addr  input  32  start byte address.
REQ-008 io_inst_req_len / io_data_req_len  input  8  AXI beats minus one.
REQ-009 io_inst_req_size / io_data_req_size  input  3  AXI beat size.
REQ-010 io_inst_resp_valid / io_data_resp_valid  output  1  read beat valid.
REQ-011 io_inst_resp_ready / io_data_resp_ready  input  1  requester accepts beat.
REQ-012 io_inst_resp_data / io_data_resp_data  output  32  beat data.
REQ-013 io_inst_resp_last / io_data_resp_last  output  1  final beat.
REQ-014 io_inst_resp_err / io_data_resp_err  output  1  beat RRESP nonzero.
REQ-015 io_axi_ar_bits_{id 4, addr 32, len 8, size 3, burst 2, lock 2, cache 4, prot 3}  output  AXI read address.
REQ-016 io_axi_ar_valid  output  1; io_axi_ar_ready  input  1.
REQ-017 io_axi_r_bits_{id 4, data 32, resp 2, last 1}  input; io_axi_r_valid input 1; io_axi_r_ready output 1.

Function
REQ-018 FSM states IDLE, ADDR, DATA; exactly one AXI read transaction outstanding at any time.
REQ-019 IDLE: if any req_valid, grant one requester, assert its req_ready for that single cycle, latch addr/len/size/owner, go ADDR next cycle.
REQ-020 Arbitration: round-robin on last grant; if only one requests, it wins; on simultaneous requests after reset, data wins.
REQ-021 req_ready SHALL be 0 outside IDLE and for the non-granted requester.
REQ-022 ADDR: ar_valid=1 with latched fields, ar_id = owner's ID parameter; fields stable until ar_ready; on ar_valid&ar_ready go DATA.
REQ-023 Constant fields: ar_burst=2'b01 (INCR), ar_lock=0, ar_cache=0, ar_prot=0; ar_valid=0 in IDLE and DATA.
REQ-024 DATA: r_ready = owner's resp_ready; owner's resp_valid = r_valid; resp_data/last pass through combinationally; err = (r_resp != 0).
REQ-025 Non-owner resp_valid SHALL be 0; r_ready=0 outside DATA.
REQ-026 r_valid&r_ready&r_last in DATA: return to IDLE next cycle; new grant earliest the following cycle.
REQ-027 r_last before len+1 beats or beats after r_last are not checked; r_last alone ends the transaction.
REQ-028 R beats with r_id not equal to owner ID are still forwarded to the owner (single-outstanding design).
REQ-029 Requester withdrawing req_valid in ADDR/DATA has no effect on the latched transaction.

Reset
REQ-030 Reset (async assert) forces IDLE, last-grant=inst (so data wins first tie), all outputs 0, latched fields 0.
REQ-031 Reset asserted mid-ADDR or mid-DATA drops ar_valid/r_ready immediately, no completion issued.
REQ-032 After reset deassert, first grant possible on the first rising edge with a req_valid.

Verification
REQ-033 Both valid after reset, data addr 0x1000 len 3 -> data_req_ready pulse, ar_id=1, ar_addr=0x1000, ar_len=3; 4 beats to data only.
REQ-034 Both valid continuously -> grants alternate data, inst, data, inst; ar_id sequence 1,0,1,0.
REQ-035 ar_ready held low 5 cycles -> ar_valid and all ar fields stable 5 cycles, DATA entered after handshake.
REQ-036 inst_resp_ready low on beat 2 -> r_ready low that cycle, beat held, no data loss, 8 beats total for len 7.
REQ-037 r_resp=2'b10 on beat 0 -> owner resp_err=1 that beat only; transaction completes normally.
REQ-038 reset pulse during DATA beat 1 -> outputs 0 same cycle, IDLE after release, fresh request granted normally.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read channel between an instruction-fetch
// requester and a data-read requester. One AXI read is outstanding at a time:
// IDLE grants a requester, ADDR presents AR, DATA forwards R beats to the owner.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// the source holds valid and its payload stable until that edge.
module axi_rd_arbiter #(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_inst_req_valid,
  output logic        io_inst_req_ready,
  input  logic [31:0] io_inst_req_addr,
  input  logic [7:0]  io_inst_req_len,
  input  logic [2:0]  io_inst_req_size,
  output logic        io_inst_resp_valid,
  input  logic        io_inst_resp_ready,
  output logic [31:0] io_inst_resp_data,
  output logic        io_inst_resp_last,
  output logic        io_inst_resp_err,
  input  logic        io_data_req_valid,
  output logic        io_data_req_ready,
  input  logic [31:0] io_data_req_addr,
  input  logic [7:0]  io_data_req_len,
  input  logic [2:0]  io_data_req_size,
  output logic        io_data_resp_valid,
  input  logic        io_data_resp_ready,
  output logic [31:0] io_data_resp_data,
  output logic        io_data_resp_last,
  output logic        io_data_resp_err,
  output logic [3:0]  io_axi_ar_bits_id,
  output logic [31:0] io_axi_ar_bits_addr,
  output logic [7:0]  io_axi_ar_bits_len,
  output logic [2:0]  io_axi_ar_bits_size,
  output logic [1:0]  io_axi_ar_bits_burst,
  output logic [1:0]  io_axi_ar_bits_lock,
  output logic [3:0]  io_axi_ar_bits_cache,
  output logic [2:0]  io_axi_ar_bits_prot,
  output logic        io_axi_ar_valid,
  input  logic        io_axi_ar_ready,
  input  logic [3:0]  io_axi_r_bits_id,
  input  logic [31:0] io_axi_r_bits_data,
  input  logic [1:0]  io_axi_r_bits_resp,
  input  logic        io_axi_r_bits_last,
  input  logic        io_axi_r_valid,
  output logic        io_axi_r_ready,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_owner_data;   // 1: current transaction belongs to the data port
  logic        r_last_data;    // 1: most recent grant went to the data port
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [2:0]  r_size;
  logic        w_grant_inst;
  logic        w_grant_data;
  logic        w_pick_data;
  logic        w_unused_rid;

  // With a single transaction in flight the R id carries no routing information.
  assign w_unused_rid = ^io_axi_r_bits_id;

  // Address channel fields come straight from the latched request.
  assign io_axi_ar_bits_id    = r_owner_data ? ID_DATA : ID_INST;
  assign io_axi_ar_bits_addr  = r_addr;
  assign io_axi_ar_bits_len   = r_len;
  assign io_axi_ar_bits_size  = r_size;
  assign io_axi_ar_bits_burst = 2'b01;
  assign io_axi_ar_bits_lock  = 2'b00;
  assign io_axi_ar_bits_cache = 4'b0000;
  assign io_axi_ar_bits_prot  = 3'b000;
  assign o_dbg_state          = r_state;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Latch the granted request and remember who won for round-robin.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_owner_data <= 1'b0;
      r_last_data  <= 1'b0;
      r_addr       <= 32'd0;
      r_len        <= 8'd0;
      r_size       <= 3'd0;
    end else if (w_grant_data || w_grant_inst) begin
      r_owner_data <= w_grant_data;
      r_last_data  <= w_grant_data;
      r_addr       <= w_grant_data ? io_data_req_addr : io_inst_req_addr;
      r_len        <= w_grant_data ? io_data_req_len  : io_inst_req_len;
      r_size       <= w_grant_data ? io_data_req_size : io_inst_req_size;
    end
  end

  // Next-state, grant and channel steering.
  always_comb begin
    w_next_state       = r_state;
    w_grant_inst       = 1'b0;
    w_grant_data       = 1'b0;
    io_inst_req_ready  = 1'b0;
    io_data_req_ready  = 1'b0;
    io_axi_ar_valid    = 1'b0;
    io_axi_r_ready     = 1'b0;
    io_inst_resp_valid = 1'b0;
    io_inst_resp_data  = 32'd0;
    io_inst_resp_last  = 1'b0;
    io_inst_resp_err   = 1'b0;
    io_data_resp_valid = 1'b0;
    io_data_resp_data  = 32'd0;
    io_data_resp_last  = 1'b0;
    io_data_resp_err   = 1'b0;
    // Data wins unless instruction also requests and data had the last grant.
    w_pick_data = io_data_req_valid && (!io_inst_req_valid || !r_last_data);
    case (r_state)
      ST_IDLE: begin
        if (!reset) begin
          w_grant_data = w_pick_data;
          w_grant_inst = io_inst_req_valid && !w_pick_data;
        end
        io_data_req_ready = w_grant_data;
        io_inst_req_ready = w_grant_inst;
        if (w_grant_data || w_grant_inst) w_next_state = ST_ADDR;
      end
      ST_ADDR: begin
        io_axi_ar_valid = 1'b1;
        if (io_axi_ar_ready) w_next_state = ST_DATA;
      end
      ST_DATA: begin
        if (r_owner_data) begin
          io_axi_r_ready     = io_data_resp_ready;
          io_data_resp_valid = io_axi_r_valid;
          io_data_resp_data  = io_axi_r_bits_data;
          io_data_resp_last  = io_axi_r_bits_last;
          io_data_resp_err   = (io_axi_r_bits_resp != 2'b00);
        end else begin
          io_axi_r_ready     = io_inst_resp_ready;
          io_inst_resp_valid = io_axi_r_valid;
          io_inst_resp_data  = io_axi_r_bits_data;
          io_inst_resp_last  = io_axi_r_bits_last;
          io_inst_resp_err   = (io_axi_r_bits_resp != 2'b00);
        end
        if (io_axi_r_valid && io_axi_r_ready && io_axi_r_bits_last) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

endmodule
